// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier datapath.
package mvm_pkg;

  localparam int unsigned K_DEF = 8;
  localparam int unsigned B_DEF = 20;

  typedef logic signed [2*B_DEF-1:0] result_t;

endpackage

// File: rtl/mvm_out_fifo.sv
// Circular word store with read/write pointers and occupancy count.
module mvm_out_fifo #(
  parameter int unsigned EW    = 41,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [EW-1:0]                wr_data_i,
  input  logic                         rd_en_i,
  output logic [EW-1:0]                rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_nxt_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != CW'(DEPTH));
  assign do_rd = rd_en_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_d = count_q + CW'(1);
      else if (!do_wr && do_rd) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o     = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign count_nxt_c_o = count_d;

endmodule

// File: rtl/mvm_out_buf.sv
// Output buffer for MVM result words: tags vector ends, tracks space and overflow.
// Optional macro MVM_OUT_BUF_RELU_EN clamps negative words to zero on out_data.
module mvm_out_buf
  import mvm_pkg::*;
#(
  parameter int unsigned K     = K_DEF,
  parameter int unsigned B     = B_DEF,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [2*B-1:0]             in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*B-1:0]             out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       can_start,
  output logic                       overflow
);

  localparam int unsigned W  = 2*B;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic          valid_q;
  logic          can_start_q;
  logic          full_c, last_c, drop_c;
  logic          wr_en, rd_en;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  head_data;

  assign full_c = (count == CW'(DEPTH));
  assign last_c = (idx_q == IW'(K-1));
  assign drop_c = in_valid && full_c;
  assign wr_en  = in_valid && !full_c;
  assign rd_en  = valid_q && out_ready;

  mvm_out_fifo #(
    .EW    (W+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (clr),
    .wr_en_i       (wr_en),
    .wr_data_i     ({last_c, in_data}),
    .rd_en_i       (rd_en),
    .rd_data_o     ({out_last, head_data}),
    .count_o       (count),
    .count_nxt_c_o (count_nxt)
  );

  // Index advances on every input word, dropped or not.
  always_comb begin
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (clr) begin
      idx_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (in_valid) idx_d = last_c ? '0 : idx_q + IW'(1);
      if (drop_c)   ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      can_start_q <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      valid_q     <= (count_nxt != '0);
      can_start_q <= ((CW'(DEPTH) - count_nxt) >= CW'(K));
    end
  end

`ifdef MVM_OUT_BUF_RELU_EN
  assign out_data = head_data[W-1] ? '0 : head_data;
`else
  assign out_data = head_data;
`endif

  assign out_valid = valid_q;
  assign can_start = can_start_q;
  assign overflow  = ovf_q;

endmodule
